layer_sequencer: RTL and testbench

Control and post-processing stage for one fully-connected layer of the MNIST network. Streams input activations and weights from one-cycle-latency memories into a bank of N_OUT parallel neurons. Sequences each neuron's Active (clear / accumulate / hold) window. Collects the neurons' Q5.11 outputs, adds a per-neuron bias with saturation, optionally applies ReLU, and writes the results serially into the next layer's activation buffer.

---
 rtl/layer_sequencer_if.sv | 31 +++
 rtl/layer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Bus bundle between layer_sequencer and its memories and neuron bank:
// control handshake, activation/weight feed, bias read and activation write.
interface layer_sequencer_if #(
  parameter int AW    = 10,
  parameter int OW    = 5,
  parameter int N_OUT = 20
);
  logic                  Start;
  logic                  Busy;
  logic                  Done;
  logic [AW-1:0]         Mem_Addr;
  logic [15:0]           Mem_X;
  logic [15:0]           X;
  logic                  Active;
  logic [16*N_OUT-1:0]   Z;
  logic [OW-1:0]         B_Addr;
  logic [15:0]           B_Data;
  logic                  Act_We;
  logic [OW-1:0]         Act_Addr;
  logic [15:0]           Act_Data;

  modport master (
    input  Start, Mem_X, Z, B_Data,
    output Busy, Done, Mem_Addr, X, Active, B_Addr, Act_We, Act_Addr, Act_Data
  );

  modport slave (
    output Start, Mem_X, Z, B_Data,
    input  Busy, Done, Mem_Addr, X, Active, B_Addr, Act_We, Act_Addr, Act_Data
  );
endinterface

// File: rtl/layer_sequencer.sv
// Sequencer and bias/saturate/activation stage for one fully-connected layer.
// Define RELU_EN to apply ReLU to the saturated outputs (hidden layers).
module layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 20,
  parameter int MAC_LAT = 2,
  parameter int AW      = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  layer_sequencer_if.master  bus
);

  localparam int CMAX = (N_IN > N_OUT) ? ((N_IN > MAC_LAT) ? N_IN : MAC_LAT)
                                       : ((N_OUT > MAC_LAT) ? N_OUT : MAC_LAT);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            active_q, active_d;
  logic            feed_q, feed_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [OW-1:0]   b_addr_q, b_addr_d;
  logic            act_we_q, act_we_d;
  logic [OW-1:0]   act_addr_q, act_addr_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      feed_q     <= 1'b0;
      mem_addr_q <= '0;
      b_addr_q   <= '0;
      act_we_q   <= 1'b0;
      act_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      active_q   <= active_d;
      feed_q     <= feed_d;
      mem_addr_q <= mem_addr_d;
      b_addr_q   <= b_addr_d;
      act_we_q   <= act_we_d;
      act_addr_q <= act_addr_d;
    end
  end

  // Outputs are registered: they are decoded from the next state/count so
  // each register shows the value belonging to the state it accompanies.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    active_d   = 1'b0;
    feed_d     = 1'b0;
    mem_addr_d = '0;
    b_addr_d   = '0;
    act_we_d   = 1'b0;
    act_addr_d = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == CW'(N_IN)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(MAC_LAT)) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == CW'(N_OUT)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d   = state_d inside {S_CLEAR, S_RUN, S_DRAIN, S_WRITE};
    done_d   = (state_d == S_DONE);
    active_d = state_d inside {S_RUN, S_DRAIN};
    feed_d   = (state_q == S_RUN) && (cnt_q < CW'(N_IN));

    if (state_d == S_RUN)
      mem_addr_d = (cnt_d < CW'(N_IN)) ? AW'(cnt_d) : AW'(N_IN - 1);

    if (state_d == S_WRITE && cnt_d < CW'(N_OUT))
      b_addr_d = OW'(cnt_d);

    if (state_d == S_WRITE && cnt_d != '0) begin
      act_we_d   = 1'b1;
      act_addr_d = OW'(cnt_d - CW'(1));
    end
  end

  logic [15:0]        z_sel;
  logic signed [16:0] sum;
  logic [15:0]        sat;
  logic [15:0]        act_val;

  always_comb begin
    z_sel = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      if (act_addr_q == OW'(i))
        z_sel = bus.Z[16*i +: 16];
  end

  assign sum = $signed({z_sel[15], z_sel}) + $signed({bus.B_Data[15], bus.B_Data});

  always_comb begin
    if (sum[16] != sum[15])
      sat = sum[16] ? 16'h8000 : 16'h7FFF;
    else
      sat = sum[15:0];
`ifdef RELU_EN
    act_val = sat[15] ? '0 : sat;
`else
    act_val = sat;
`endif
  end

  // B_Data for address j-1 arrives in the same cycle as write j-1, so the
  // write data is formed from that read and the registered write address.
  assign bus.Act_Data = act_we_q ? act_val : '0;
  assign bus.Act_We   = act_we_q;
  assign bus.Act_Addr = act_addr_q;
  assign bus.B_Addr   = b_addr_q;
  assign bus.Mem_Addr = mem_addr_q;
  assign bus.Active   = active_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.X        = feed_q ? bus.Mem_X : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed, table-driven bench for layer_sequencer with N_IN=4, N_OUT=2, MAC_LAT=2.
module tb_layer_sequencer;
  localparam int N_IN = 4, N_OUT = 2, MAC_LAT = 2, AW = 2, OW = 1;
`ifdef RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  layer_sequencer_if #(.AW(AW), .OW(OW), .N_OUT(N_OUT)) bus ();

  layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT), .AW(AW), .OW(OW)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Environment: input buffer, bias memory, and two unit-weight neurons.
  logic        xmode = 1'b0, zmode = 1'b0;
  logic [15:0] zf0 = '0, zf1 = '0, bt0 = '0, bt1 = '0;
  logic [15:0] memx = '0, bdat = '0, acc = '0, zr = '0;

  always @(posedge Clk) begin
    memx <= xmode ? (16'(bus.Mem_Addr) + 16'd1) : 16'h0800;
    bdat <= (bus.B_Addr == 1'b0) ? bt0 : bt1;
    if (bus.Active) begin
      acc <= acc + bus.X;
      zr  <= acc + bus.X;
    end else begin
      acc <= '0;
    end
  end

  assign bus.Mem_X  = memx;
  assign bus.B_Data = bdat;
  assign bus.Z      = zmode ? {zf1, zf0} : {zr, zr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        xm, zm;
    logic [15:0] z0, z1, b0, b1;
    logic [15:0] lin0, lin1, relu0, relu1;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v, input bit poke);
    int busy_n, done_n, done_c, wr_n;
    logic [15:0] wa[4], wd[4];
    int wc[4];
    logic [15:0] xe;
    logic [15:0] e0, e1;
    busy_n = 0; done_n = 0; done_c = -1; wr_n = 0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; wc[i] = -1; end
    e0 = RELU ? v.relu0 : v.lin0;
    e1 = RELU ? v.relu1 : v.lin1;
    xmode = v.xm; zmode = v.zm; zf0 = v.z0; zf1 = v.z1; bt0 = v.b0; bt1 = v.b1;
    @(negedge Clk);
    bus.Start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Clk);
      if (bus.Busy) busy_n++;
      if (bus.Done) begin done_n++; done_c = c; end
      if (bus.Act_We) begin
        if (wr_n < 4) begin
          wa[wr_n] = 16'(bus.Act_Addr); wd[wr_n] = bus.Act_Data; wc[wr_n] = c;
        end
        wr_n++;
      end
      xe = (c >= 2 && c <= 5) ? (v.xm ? 16'(c - 1) : 16'h0800) : 16'h0000;
      chk("x_feed", 32'(bus.X), 32'(xe));
      chk("active", 32'(bus.Active), 32'(c >= 1 && c <= 8));
      if (c <= 5) chk("mem_addr", 32'(bus.Mem_Addr), (c == 0) ? 0 : ((c - 1 < 3) ? c - 1 : 3));
      bus.Start = poke && (c == 3 || c == 12);
    end
    chk("busy_cycles", busy_n, 12);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_c, 12);
    chk("write_count", wr_n, 2);
    chk("wr0_addr", 32'(wa[0]), 0);
    chk("wr0_data", 32'(wd[0]), 32'(e0));
    chk("wr0_cycle", wc[0], 10);
    chk("wr1_addr", 32'(wa[1]), 1);
    chk("wr1_data", 32'(wd[1]), 32'(e1));
    chk("wr1_cycle", wc[1], 11);
  endtask

  initial begin
    int we_n, done_n, busy_n, c;
    bit seen;
    bus.Start = 1'b0;

    //          xm    zm    z0       z1       b0       b1       lin0     lin1     relu0    relu1
    vt[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'hF000, 16'h2800, 16'h1000, 16'h2800, 16'h1000};
    vt[1] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'hF000, 16'h080A, 16'hF00A, 16'h080A, 16'h0000};
    vt[2] = '{1'b0, 1'b1, 16'h7000, 16'h9000, 16'h2000, 16'hE000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    vt[3] = '{1'b0, 1'b1, 16'h8000, 16'h1234, 16'h8000, 16'h0001, 16'h8000, 16'h1235, 16'h0000, 16'h1235};
    vt[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF};
    vt[5] = '{1'b0, 1'b1, 16'h4000, 16'hC000, 16'h4000, 16'h3000, 16'h7FFF, 16'hF000, 16'h7FFF, 16'h0000};

    // Reset and idle
    repeat (2) @(negedge Clk);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_active", 32'(bus.Active), 0);
    chk("rst_x", 32'(bus.X), 0);
    chk("rst_mem_addr", 32'(bus.Mem_Addr), 0);
    chk("rst_b_addr", 32'(bus.B_Addr), 0);
    chk("rst_act_we", 32'(bus.Act_We), 0);
    chk("rst_act_addr", 32'(bus.Act_Addr), 0);
    chk("rst_act_data", 32'(bus.Act_Data), 0);
    Reset_n = 1'b1;
    we_n = 0; busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.Act_We) we_n++;
      if (bus.Busy) busy_n++;
    end
    chk("idle_writes", we_n, 0);
    chk("idle_busy", busy_n, 0);

    // Table-driven runs; vector 2 also pokes Start during RUN and in the Done cycle
    for (int i = 0; i < 6; i++) run_vec(vt[i], i == 2);

    // Start in the IDLE cycle right after Done starts a second run
    xmode = 1'b0; zmode = 1'b0; bt0 = 16'h0800; bt1 = 16'hF000;
    @(negedge Clk);
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge Clk);
      seen = bus.Done;
    end
    chk("chain_first_done", 32'(seen), 1);
    @(negedge Clk);
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    chk("chain_busy", 32'(bus.Busy), 1);
    c = 0; seen = 1'b0;
    while (c < 30 && !seen) begin
      @(negedge Clk);
      c++;
      seen = bus.Done;
    end
    chk("chain_second_done", c, 12);

    // Reset pulse in the middle of RUN
    xmode = 1'b1;
    repeat (3) @(negedge Clk);
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("pre_rst_mem_addr", 32'(bus.Mem_Addr), 2);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_active", 32'(bus.Active), 0);
    chk("mid_rst_x", 32'(bus.X), 0);
    chk("mid_rst_mem_addr", 32'(bus.Mem_Addr), 0);
    chk("mid_rst_act_we", 32'(bus.Act_We), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    we_n = 0; done_n = 0; busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.Act_We) we_n++;
      if (bus.Done) done_n++;
      if (bus.Busy) busy_n++;
    end
    chk("post_rst_writes", we_n, 0);
    chk("post_rst_done", done_n, 0);
    chk("post_rst_busy", busy_n, 0);

    // Sequencer is back in IDLE and runs normally
    run_vec(vt[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
